fifo_word_unpacker: RTL and testbench

Reader-side width converter that pops wide words from a `fifo` output port and emits them as a sequence of narrow beats on a downstream valid/ready stream. It sits directly behind a `fifo` instance, with `din`/`input_valid`/`input_ready` wired to the FIFO's `qout`/`output_valid`/`output_ready`. It lets a wide FIFO feed a narrow consumer, such as a PE array column, without stalling the FIFO more than necessary.

---
 rtl/fifo_word_unpacker.sv | 77 +++++++
 tb/tb_fifo_word_unpacker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_unpacker.sv
// Width converter behind a FIFO read port: pops one IN_WIDTH word and replays
// it as RATIO OUT_WIDTH beats, least-significant beat first.
module fifo_word_unpacker #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                                       clk,
  input  logic                                       arst_in,
  input  logic [IN_WIDTH-1:0]                        din,
  input  logic                                       input_valid,
  output logic                                       input_ready,
  output logic [OUT_WIDTH-1:0]                       qout,
  output logic                                       output_valid,
  input  logic                                       output_ready,
  output logic                                       output_last,
  output logic [$clog2(IN_WIDTH/OUT_WIDTH)-1:0]      beat_idx
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

  localparam logic EMPTY = 1'b0;
  localparam logic HOLD  = 1'b1;

  generate
    if (RATIO < 2 || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_ratio
      $error("fifo_word_unpacker: IN_WIDTH must be a multiple of OUT_WIDTH with RATIO >= 2");
    end
  endgenerate

  logic [IN_WIDTH-1:0] word_buf;
  logic [CNT_W-1:0]    cnt;
  logic                full;
  logic                at_last;
  logic                accept;
  logic                pop;

  assign at_last      = (cnt == LAST_BEAT);
  assign output_valid = (full == HOLD);
  // Refill is allowed in the same cycle the final beat leaves, so a steady
  // stream runs without a bubble between words.
  assign input_ready  = (full == EMPTY) || (output_ready && at_last);
  assign accept       = input_valid && input_ready;
  assign pop          = output_valid && output_ready;

  assign qout        = word_buf[int'(cnt) * OUT_WIDTH +: OUT_WIDTH];
  assign beat_idx    = cnt;
  assign output_last = output_valid && at_last;

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      word_buf <= '0;
      cnt      <= '0;
      full     <= EMPTY;
    end else if (full == EMPTY) begin
      if (accept) begin
        word_buf <= din;
        cnt      <= '0;
        full     <= HOLD;
      end
    end else if (pop) begin
      // Explicit wrap compare keeps non-power-of-two ratios in range.
      if (!at_last) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        if (accept) begin
          word_buf <= din;
        end else begin
          full <= EMPTY;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Directed bench for fifo_word_unpacker (64-bit words, 16-bit beats), with a
// queue-based FIFO model feeding it for the integration scenario.
module tb_fifo_word_unpacker;

  logic        clk = 1'b0;
  logic        arst_in = 1'b1;
  logic [63:0] din = '0;
  logic        input_valid = 1'b0;
  logic        input_ready;
  logic [15:0] qout;
  logic        output_valid;
  logic        output_ready = 1'b0;
  logic        output_last;
  logic [1:0]  beat_idx;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_word_unpacker #(.IN_WIDTH(64), .OUT_WIDTH(16)) dut (
    .clk(clk), .arst_in(arst_in), .din(din), .input_valid(input_valid),
    .input_ready(input_ready), .qout(qout), .output_valid(output_valid),
    .output_ready(output_ready), .output_last(output_last), .beat_idx(beat_idx)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #1;
    n_checks++;
    if (output_valid !== 1'b0 || qout !== 16'h0 || input_ready !== 1'b1 ||
        output_last !== 1'b0 || beat_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b qout=%h ready=%b last=%b idx=%0d, required 0 0000 1 0 0",
               output_valid, qout, input_ready, output_last, beat_idx);
    end
    @(negedge clk);
    arst_in = 1'b0;
  endtask

  task automatic test_single_word();
    logic [15:0] exp_b [4];
    exp_b = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    @(negedge clk);
    din = 64'h4444_3333_2222_1111; input_valid = 1'b1; output_ready = 1'b1;
    #1;
    n_checks++;
    if (input_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_ready_empty: ready=%b, required 1", input_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      input_valid = 1'b0; din = '0;
      #1;
      n_checks++;
      if (output_valid !== 1'b1 || qout !== exp_b[k] || beat_idx !== k[1:0] ||
          output_last !== (k == 3)) begin
        n_fail++;
        $display("FAIL single_beat%0d: valid=%b qout=%h idx=%0d last=%b, required 1 %h %0d %b",
                 k, output_valid, qout, beat_idx, output_last, exp_b[k], k, (k == 3));
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (output_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: valid=%b, required 0", output_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_b [8];
    exp_b = '{16'h0001, 16'h1002, 16'h1003, 16'h1004,
              16'h0002, 16'h2002, 16'h2003, 16'h2004};
    @(negedge clk);
    din = 64'h1004_1003_1002_0001; input_valid = 1'b1; output_ready = 1'b1;
    #1;
    n_checks++;
    if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_initial: valid=%b ready=%b, required 0 1", output_valid, input_ready);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      din = 64'h2004_2003_2002_0002; input_valid = (c < 4);
      #1;
      n_checks++;
      if (output_valid !== 1'b1 || qout !== exp_b[c] || output_last !== ((c % 4) == 3) ||
          input_ready !== ((c % 4) == 3)) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: valid=%b qout=%h last=%b ready=%b, required 1 %h %b %b",
                 c, output_valid, qout, output_last, input_ready, exp_b[c],
                 ((c % 4) == 3), ((c % 4) == 3));
      end
    end
    @(negedge clk); input_valid = 1'b0; #1;
    n_checks++;
    if (output_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: valid=%b, required 0", output_valid);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    din = 64'hDDDD_CCCC_BBBB_AAAA; input_valid = 1'b1; output_ready = 1'b1;
    @(negedge clk); input_valid = 1'b0; din = '0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      output_ready = 1'b0;
      #1;
      n_checks++;
      if (output_valid !== 1'b1 || qout !== 16'hCCCC || beat_idx !== 2'd2 || input_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall%0d: valid=%b qout=%h idx=%0d ready=%b, required 1 cccc 2 0",
                 c, output_valid, qout, beat_idx, input_ready);
      end
    end
    @(negedge clk); output_ready = 1'b1; #1;
    n_checks++;
    if (qout !== 16'hCCCC || beat_idx !== 2'd2 || input_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: qout=%h idx=%0d ready=%b, required cccc 2 0", qout, beat_idx, input_ready);
    end
    @(negedge clk); #1;
    n_checks++;
    if (output_valid !== 1'b1 || qout !== 16'hDDDD || output_last !== 1'b1 || input_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_beat3: valid=%b qout=%h last=%b ready=%b, required 1 dddd 1 1",
               output_valid, qout, output_last, input_ready);
    end
    @(negedge clk); #1;
    n_checks++;
    if (output_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: valid=%b, required 0", output_valid);
    end
  endtask

  task automatic test_hold_while_busy();
    logic [15:0] exp_b [4];
    exp_b = '{16'h5555, 16'h6666, 16'h7777, 16'h8888};
    @(negedge clk);
    din = 64'h8888_7777_6666_5555; input_valid = 1'b1; output_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      input_valid = (k < 3); din = {$urandom, $urandom};
      #1;
      n_checks++;
      if (qout !== exp_b[k] || input_ready !== (k == 3)) begin
        n_fail++;
        $display("FAIL busy_beat%0d: qout=%h ready=%b, required %h %b", k, qout, input_ready, exp_b[k], (k == 3));
      end
    end
    @(negedge clk); input_valid = 1'b0; #1;
    n_checks++;
    if (output_valid !== 1'b0) begin
      n_fail++; $display("FAIL busy_drain: valid=%b, required 0", output_valid);
    end
  endtask

  task automatic test_reset_mid_word();
    @(negedge clk);
    din = 64'h0D0D_0C0C_0B0B_0A0A; input_valid = 1'b1; output_ready = 1'b1;
    @(negedge clk); input_valid = 1'b0; din = '0;
    @(negedge clk); output_ready = 1'b0;
    #1 arst_in = 1'b1;
    #1;
    n_checks++;
    if (output_valid !== 1'b0 || qout !== 16'h0 || input_ready !== 1'b1 ||
        beat_idx !== 2'd0 || output_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: valid=%b qout=%h ready=%b idx=%0d last=%b, required 0 0000 1 0 0",
               output_valid, qout, input_ready, beat_idx, output_last);
    end
    @(negedge clk); arst_in = 1'b0; #1;
    n_checks++;
    if (output_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_empty: valid=%b, required 0", output_valid);
    end
    din = 64'h4321_8765_CBA9_0FED; input_valid = 1'b1; output_ready = 1'b1;
    @(negedge clk); input_valid = 1'b0; din = '0; #1;
    n_checks++;
    if (output_valid !== 1'b1 || beat_idx !== 2'd0 || qout !== 16'h0FED) begin
      n_fail++;
      $display("FAIL reset_next_word: valid=%b idx=%0d qout=%h, required 1 0 0fed", output_valid, beat_idx, qout);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_integration();
    logic [63:0] fifo_q [$];
    logic [15:0] exp_q [$];
    logic [63:0] w;
    int idx = 0;
    int cyc = 0;
    for (int i = 0; i < 10; i++) begin
      w = {$urandom, $urandom};
      fifo_q.push_back(w);
      for (int k = 0; k < 4; k++) exp_q.push_back(16'((w >> (16 * k)) & 64'hFFFF));
    end
    while (idx < 40 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      input_valid  = (fifo_q.size() > 0);
      din          = input_valid ? fifo_q[0] : '0;
      output_ready = 1'($urandom_range(0, 1));
      #1;
      if (output_valid && output_ready) begin
        n_checks++;
        if (qout !== exp_q[idx] || beat_idx !== 2'(idx % 4)) begin
          n_fail++;
          $display("FAIL integ_beat%0d: qout=%h idx=%0d, required %h %0d", idx, qout, beat_idx, exp_q[idx], idx % 4);
        end
        idx++;
      end
      if (input_valid && input_ready) void'(fifo_q.pop_front());
    end
    @(negedge clk); input_valid = 1'b0; output_ready = 1'b0; #1;
    n_checks++;
    if (idx != 40 || fifo_q.size() != 0 || output_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL integ_end: beats=%0d fifo_left=%0d valid=%b, required 40 0 0", idx, fifo_q.size(), output_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_hold_while_busy();
    test_reset_mid_word();
    test_integration();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
